// File: rtl/display_timing_controller.sv
// display_timing_controller: raster timing generator with line-fetch scheduling and sticky underflow detection
module display_timing_controller #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT = 16,
  parameter int H_SYNC = 96,
  parameter int H_BACK = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT = 10,
  parameter int V_SYNC = 2,
  parameter int V_BACK = 33,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        aClock,
  input  logic        aReset,
  input  logic        anInEnable,
  input  logic        anInLineAck,
  input  logic        anInClearUnderflow,
  output logic        anOutHorizontalSync,
  output logic        anOutVerticalSync,
  output logic        anOutDisplayEnabled,
  output logic [11:0] anOutX,
  output logic [11:0] anOutY,
  output logic        anOutFrameStart,
  output logic        anOutLineRequest,
  output logic [11:0] anOutLineIndex,
  output logic        anOutUnderflow
);
  localparam logic [11:0] H_LAST = 12'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [11:0] V_LAST = 12'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [11:0] H_ACT = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT = 12'(V_ACTIVE);
  localparam logic [11:0] H_SS = 12'(H_ACTIVE + H_FRONT);
  localparam logic [11:0] H_SE = 12'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [11:0] V_SS = 12'(V_ACTIVE + V_FRONT);
  localparam logic [11:0] V_SE = 12'(V_ACTIVE + V_FRONT + V_SYNC);
  logic [11:0] h_cnt, v_cnt, h_nxt, v_nxt, nxt_line, idx;
  logic h_wrap, issue, late, req, unf, hs, vs, de, fs;
  always_comb begin
    h_wrap = h_cnt == H_LAST;
    h_nxt = anInEnable ? (h_wrap ? '0 : h_cnt + 12'd1) : h_cnt;
    v_nxt = (anInEnable && h_wrap) ? (v_cnt == V_LAST ? '0 : v_cnt + 12'd1) : v_cnt;
    nxt_line = v_nxt == V_LAST ? '0 : v_nxt + 12'd1;
    issue = anInEnable && h_nxt == H_ACT && nxt_line < V_ACT;
    late = req && !anInLineAck && anInEnable && h_nxt == '0 && v_nxt == idx;
  end
  always_ff @(posedge aClock) begin
    if (aReset) begin
      h_cnt <= H_LAST;
      v_cnt <= V_LAST;
      hs <= SYNC_ACTIVE_LOW;
      vs <= SYNC_ACTIVE_LOW;
      de <= 1'b0;
      fs <= 1'b0;
      req <= 1'b0;
      idx <= '0;
      unf <= 1'b0;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      de <= h_nxt < H_ACT && v_nxt < V_ACT;
      hs <= (h_nxt >= H_SS && h_nxt < H_SE) ^ SYNC_ACTIVE_LOW;
      vs <= (v_nxt >= V_SS && v_nxt < V_SE) ^ SYNC_ACTIVE_LOW;
      fs <= anInEnable && h_nxt == '0 && v_nxt == '0;
      req <= issue || (req && !anInLineAck && !late);
      idx <= issue ? nxt_line : idx;
      unf <= late || (unf && !anInClearUnderflow);
    end
  end
  assign anOutHorizontalSync = hs;
  assign anOutVerticalSync = vs;
  assign anOutDisplayEnabled = de;
  assign anOutX = h_cnt;
  assign anOutY = v_cnt;
  assign anOutFrameStart = fs;
  assign anOutLineRequest = req;
  assign anOutLineIndex = idx;
  assign anOutUnderflow = unf;
endmodule

// File: tb/tb_display_timing_controller.sv
// tb_display_timing_controller: directed self-checking bench for the raster timing controller
module tb_display_timing_controller;
  logic clk = 1'b0;
  logic rst, en, ack, clr;
  logic hs, vs, de, fs, req, unf;
  logic [11:0] x, y, idx;
  int checks = 0;
  int errors = 0;
  bit auto_ack = 1'b0;
  always #5 clk = ~clk;
  display_timing_controller #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .aClock(clk),
    .aReset(rst),
    .anInEnable(en),
    .anInLineAck(ack),
    .anInClearUnderflow(clr),
    .anOutHorizontalSync(hs),
    .anOutVerticalSync(vs),
    .anOutDisplayEnabled(de),
    .anOutX(x),
    .anOutY(y),
    .anOutFrameStart(fs),
    .anOutLineRequest(req),
    .anOutLineIndex(idx),
    .anOutUnderflow(unf)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_ack) ack = req;
  endtask
  task automatic goto(input int gx, input int gy);
    for (int i = 0; i < 300 && !(x == 12'(gx) && y == 12'(gy)); i++) tick();
    chk("goto", {8'd0, x, y}, 32'(gx * 4096 + gy));
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_x"}, 32'(x), 13);
    chk({tag, "_y"}, 32'(y), 6);
    chk({tag, "_hs"}, 32'(hs), 1);
    chk({tag, "_vs"}, 32'(vs), 1);
    chk({tag, "_de"}, 32'(de), 0);
    chk({tag, "_fs"}, 32'(fs), 0);
    chk({tag, "_req"}, 32'(req), 0);
    chk({tag, "_idx"}, 32'(idx), 0);
    chk({tag, "_unf"}, 32'(unf), 0);
  endtask
  initial begin
    int px, py;
    rst = 1'b1; en = 1'b0; ack = 1'b0; clr = 1'b0;
    tick();
    tick();
    chk_reset("rst");
    rst = 1'b0; en = 1'b1; auto_ack = 1'b1;
    tick();
    chk("c0_x", 32'(x), 0);
    chk("c0_y", 32'(y), 0);
    chk("c0_de", 32'(de), 1);
    chk("c0_fs", 32'(fs), 1);
    chk("c0_hs", 32'(hs), 1);
    chk("c0_vs", 32'(vs), 1);
    for (int c = 1; c <= 98; c++) begin
      tick();
      px = c % 14;
      py = (c / 14) % 7;
      chk("f_x", 32'(x), 32'(px));
      chk("f_y", 32'(y), 32'(py));
      chk("f_hs", 32'(hs), 32'(!(px >= 10 && px < 12)));
      chk("f_vs", 32'(vs), 32'(py != 5));
      chk("f_de", 32'(de), 32'(px < 8 && py < 4));
      chk("f_fs", 32'(fs), 32'(px == 0 && py == 0));
      chk("f_req", 32'(req), 32'(px == 8 && (py <= 2 || py == 6)));
      if (px == 8 && (py <= 2 || py == 6)) chk("f_idx", 32'(idx), 32'(py == 6 ? 0 : py + 1));
      chk("f_unf", 32'(unf), 0);
    end
    auto_ack = 1'b0; ack = 1'b0;
    for (int c = 99; c <= 112; c++) begin
      tick();
      px = c % 14;
      py = (c / 14) % 7;
      chk("late_req", 32'(req), 32'(py == 0 && px >= 8));
      if (py == 0 && px >= 8) chk("late_idx", 32'(idx), 1);
      chk("late_unf", 32'(unf), 32'(c == 112));
    end
    chk("late_pos", {8'd0, x, y}, 32'(0 * 4096 + 1));
    auto_ack = 1'b1;
    for (int c = 113; c <= 210; c++) begin
      tick();
      chk("sticky_unf", 32'(unf), 1);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_unf", 32'(unf), 0);
    auto_ack = 1'b0; ack = 1'b0;
    goto(13, 1);
    chk("edge_req", 32'(req), 1);
    chk("edge_idx", 32'(idx), 2);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("edge_ack_req", 32'(req), 0);
    chk("edge_ack_unf", 32'(unf), 0);
    goto(13, 2);
    chk("setclr_req", 32'(req), 1);
    chk("setclr_idx", 32'(idx), 3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("setclr_unf", 32'(unf), 1);
    chk("setclr_req_drop", 32'(req), 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr2_unf", 32'(unf), 0);
    auto_ack = 1'b1;
    goto(3, 2);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("frz_x", 32'(x), 3);
      chk("frz_y", 32'(y), 2);
      chk("frz_de", 32'(de), 1);
      chk("frz_hs", 32'(hs), 1);
      chk("frz_vs", 32'(vs), 1);
      chk("frz_fs", 32'(fs), 0);
    end
    en = 1'b1;
    tick();
    chk("unfrz_x", 32'(x), 4);
    auto_ack = 1'b0; ack = 1'b0;
    goto(9, 2);
    chk("frzreq_req", 32'(req), 1);
    chk("frzreq_idx", 32'(idx), 3);
    en = 1'b0;
    tick();
    chk("frzreq_hold", 32'(req), 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("frzack_req", 32'(req), 0);
    chk("frzack_x", 32'(x), 9);
    en = 1'b1;
    goto(0, 3);
    chk("frzack_unf", 32'(unf), 0);
    auto_ack = 1'b1;
    goto(0, 0);
    chk("fs00", 32'(fs), 1);
    en = 1'b0;
    tick();
    chk("fs_frz", 32'(fs), 0);
    chk("fs_frz_x", 32'(x), 0);
    en = 1'b1;
    goto(13, 0);
    auto_ack = 1'b0; ack = 1'b0;
    goto(9, 1);
    chk("midrst_req", 32'(req), 1);
    chk("midrst_idx", 32'(idx), 2);
    rst = 1'b1;
    tick();
    chk_reset("midrst");
    rst = 1'b0;
    tick();
    chk("rel_x", 32'(x), 0);
    chk("rel_y", 32'(y), 0);
    chk("rel_fs", 32'(fs), 1);
    chk("rel_de", 32'(de), 1);
    chk("rel_unf", 32'(unf), 0);
    chk("rel_req", 32'(req), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
